// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, opcodes and fetch state encoding
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction memory req/ack bus between fetch unit and memory
interface fetch_pc_unit_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection from Jump/Branch/Zero
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic [WORD_W-1:0] instr,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] jump_target;
    logic [WORD_W-1:0] branch_target;
    logic [WORD_W-1:0] branch_offset;
    logic              unused_opcode;

    assign unused_opcode = ^instr[31:26];

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    // Jump wins over a taken branch when the control unit raises both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register and instruction fetch FSM (IDLE/FETCH/EXEC/HALT)
// Optional retired-instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                TIMEOUT_CYC = 16,
    parameter int                CNT_W       = 5
) (
    input  logic              CLK,
    input  logic              RST,
    fetch_pc_unit_if.master   imem,
    input  logic              stall,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Zero,
    output logic [5:0]        OPCODES,
    output logic [5:0]        Funct,
    output logic [WORD_W-1:0] Instr,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] PCPlus4,
    output logic              instr_valid,
    output logic              fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (Branch),
        .jump     (Jump),
        .zero     (Zero),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
            ST_FETCH: begin
                // An ack landing on the final wait cycle still counts as a hit.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_EXEC;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cnt_d   = CNT_W'(TIMEOUT_CYC);
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ST_HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (state_q == ST_EXEC && !stall) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_cnt = retired_q;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign Instr          = instr_q;
    assign OPCODES        = instr_q[31:26];
    assign Funct          = instr_q[5:0];
    assign PC             = pc_q;
    assign PCPlus4        = pc_plus4;
    assign instr_valid    = valid_q;
    assign fetch_err      = err_q;

endmodule
